note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 155 +++++++++++++++
 tb/tb_note_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Melody / sound-effect sequencer: walks a melody ROM one note per beat and can
// interrupt it with a fixed-pitch sound effect, driving a buzzer tone generator.
module note_sequencer #(
    parameter int BEAT_CYCLES = 25000000,
    parameter int SONG_LEN    = 32,
    parameter int SFX_BEATS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        stop,
    input  logic        loop,
    input  logic        sfx_req,
    input  logic [21:0] sfx_div,
    input  logic        vol_up,
    input  logic        vol_dn,
    output logic [4:0]  mel_addr,
    input  logic [21:0] mel_note,
    output logic [21:0] note_div,
    output logic [3:0]  vol_num,
    output logic        mute,
    output logic        busy,
    output logic        beat,
    output logic        sfx_ack,
    output logic        done,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(BEAT_CYCLES);
    localparam int SW = $clog2(SFX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        SFX  = 2'd2
    } state_t;

    state_t        state;
    state_t        ret;
    logic [CW-1:0] beat_cnt;
    logic [SW-1:0] sfx_cnt;
    logic          last_tick;
    logic          song_end;
    logic          sfx_end;

    assign last_tick = (beat_cnt == CW'(BEAT_CYCLES - 1));
    assign song_end  = last_tick && (mel_addr == 5'(SONG_LEN - 1)) && !loop;
    assign sfx_end   = last_tick && (sfx_cnt == SW'(SFX_BEATS - 1));

    assign busy      = (state != IDLE);
    assign mute      = (state == IDLE) || (note_div == 22'd0);
    assign dbg_state = state;

    // All control inputs are single-cycle pulses; stop outranks sfx_req, which outranks play.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ret      <= IDLE;
            mel_addr <= 5'd0;
            note_div <= 22'd0;
            beat_cnt <= '0;
            sfx_cnt  <= '0;
            beat     <= 1'b0;
            sfx_ack  <= 1'b0;
            done     <= 1'b0;
        end else begin
            beat    <= 1'b0;
            sfx_ack <= 1'b0;
            done    <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                mel_addr <= 5'd0;
                note_div <= 22'd0;
                beat_cnt <= '0;
                sfx_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sfx_req) begin
                            state    <= SFX;
                            ret      <= IDLE;
                            note_div <= sfx_div;
                            beat_cnt <= '0;
                            sfx_cnt  <= '0;
                            sfx_ack  <= 1'b1;
                        end else if (play) begin
                            state    <= PLAY;
                            mel_addr <= 5'd0;
                            beat_cnt <= '0;
                            note_div <= mel_note;
                        end
                    end
                    PLAY: begin
                        if (sfx_req) begin
                            state    <= SFX;
                            ret      <= PLAY;
                            note_div <= sfx_div;
                            beat_cnt <= '0;
                            sfx_cnt  <= '0;
                            sfx_ack  <= 1'b1;
                        end else begin
                            // The last note keeps its divider when the song ends; mute covers it.
                            if (!song_end)
                                note_div <= mel_note;
                            if (last_tick) begin
                                beat_cnt <= '0;
                                beat     <= 1'b1;
                                if (mel_addr == 5'(SONG_LEN - 1)) begin
                                    mel_addr <= 5'd0;
                                    if (!loop) begin
                                        state <= IDLE;
                                        done  <= 1'b1;
                                    end
                                end else begin
                                    mel_addr <= mel_addr + 5'd1;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    SFX: begin
                        if (last_tick) begin
                            beat_cnt <= '0;
                            beat     <= 1'b1;
                            if (sfx_end) begin
                                state   <= ret;
                                sfx_cnt <= '0;
                                // mel_addr never moved, so mel_note already holds the interrupted note.
                                if (ret == PLAY)
                                    note_div <= mel_note;
                            end else begin
                                sfx_cnt <= sfx_cnt + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vol_num <= 4'd3;
        end else if (vol_up && !vol_dn && vol_num < 4'd5) begin
            vol_num <= vol_num + 4'd1;
        end else if (vol_dn && !vol_up && vol_num > 4'd1) begin
            vol_num <= vol_num - 4'd1;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: behavioural model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_note_sequencer;

    localparam int BC = 4;
    localparam int SL = 4;
    localparam int SB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic        sfx_req = 1'b0;
    logic [21:0] sfx_div = 22'd0;
    logic        vol_up = 1'b0;
    logic        vol_dn = 1'b0;
    logic [4:0]  mel_addr;
    logic [21:0] mel_note = 22'd0;
    logic [21:0] note_div;
    logic [3:0]  vol_num;
    logic        mute;
    logic        busy;
    logic        beat;
    logic        sfx_ack;
    logic        done;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [21:0] rom [4] = '{22'd100, 22'd0, 22'd300, 22'd400};

    note_sequencer #(.BEAT_CYCLES(BC), .SONG_LEN(SL), .SFX_BEATS(SB)) dut (
        .clk(clk), .rst(rst), .play(play), .stop(stop), .loop(loop),
        .sfx_req(sfx_req), .sfx_div(sfx_div), .vol_up(vol_up), .vol_dn(vol_dn),
        .mel_addr(mel_addr), .mel_note(mel_note), .note_div(note_div),
        .vol_num(vol_num), .mute(mute), .busy(busy), .beat(beat),
        .sfx_ack(sfx_ack), .done(done), .dbg_state(dbg_state)
    );

    // ---- clock / melody ROM (one-cycle read latency) ----
    always #5 clk = ~clk;

    always @(posedge clk) mel_note <= rom[mel_addr[1:0]];

    // ---- checker ----
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model ----
    typedef enum {M_IDLE, M_PLAY, M_SFX} mstate_t;
    mstate_t     m_st = M_IDLE;
    mstate_t     m_ret = M_IDLE;
    int          m_e = 0;
    int          m_addr = 0;
    int          m_a1 = 0;
    int          m_a2 = 0;
    int          m_vol = 3;
    logic [21:0] m_sfx = 22'd0;
    logic [21:0] m_nd = 22'd0;
    logic        m_beat = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_done = 1'b0;

    task automatic enter_sfx(input mstate_t r);
        m_st  = M_SFX;
        m_ret = r;
        m_e   = 0;
        m_sfx = sfx_div;
        m_ack = 1'b1;
    endtask

    task automatic model_step();
        m_beat = 1'b0; m_ack = 1'b0; m_done = 1'b0;
        m_a2 = m_a1;
        m_a1 = m_addr;
        if (vol_up && !vol_dn && m_vol < 5) m_vol++;
        if (vol_dn && !vol_up && m_vol > 1) m_vol--;
        if (stop) begin
            m_st = M_IDLE; m_addr = 0; m_e = 0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (sfx_req) enter_sfx(M_IDLE);
                    else if (play) begin m_st = M_PLAY; m_addr = 0; m_e = 0; end
                end
                M_PLAY: begin
                    if (sfx_req) enter_sfx(M_PLAY);
                    else begin
                        m_e++;
                        if (m_e % BC == 0) begin
                            m_beat = 1'b1;
                            if (m_addr == SL - 1) begin
                                m_addr = 0;
                                if (!loop) begin m_st = M_IDLE; m_done = 1'b1; end
                            end else m_addr++;
                        end
                    end
                end
                default: begin
                    m_e++;
                    if (m_e % BC == 0) m_beat = 1'b1;
                    if (m_e == SB * BC) begin m_st = m_ret; m_e = 0; end
                end
            endcase
        end
        // In PLAY the divider is the ROM word addressed two cycles earlier.
        if (m_st == M_PLAY) m_nd = rom[m_a2];
        else if (m_st == M_SFX) m_nd = m_sfx;
        else if (stop) m_nd = 22'd0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_st = M_IDLE; m_ret = M_IDLE; m_e = 0; m_addr = 0; m_a1 = 0; m_a2 = 0;
                m_vol = 3; m_sfx = 22'd0; m_nd = 22'd0;
                m_beat = 1'b0; m_ack = 1'b0; m_done = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // ---- per-cycle compare against the model ----
    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_mel_addr", int'(mel_addr), m_addr);
            check("cmp_note_div", int'(note_div), int'(m_nd));
            check("cmp_vol_num", int'(vol_num), m_vol);
            check("cmp_mute", int'(mute), int'((m_st == M_IDLE) || (m_nd == 22'd0)));
            check("cmp_busy", int'(busy), int'(m_st != M_IDLE));
            check("cmp_beat", int'(beat), int'(m_beat));
            check("cmp_sfx_ack", int'(sfx_ack), int'(m_ack));
            check("cmp_done", int'(done), int'(m_done));
        end
    end

    // ---- driver tasks (called on a negedge, return on the next one) ----
    task automatic pulse_play();
        play = 1'b1; @(negedge clk); play = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic pulse_sfx(input logic [21:0] div, input logic with_play);
        sfx_req = 1'b1; sfx_div = div; play = with_play;
        @(negedge clk);
        sfx_req = 1'b0; play = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_addr"}, int'(mel_addr), 0);
        check({tag, "_nd"}, int'(note_div), 0);
        check({tag, "_vol"}, int'(vol_num), 3);
        check({tag, "_mute"}, int'(mute), 1);
        check({tag, "_beat"}, int'(beat), 0);
        check({tag, "_ack"}, int'(sfx_ack), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // ---- directed scenarios ----
    int vup_exp[3] = '{4, 5, 5};
    int vdn_exp[5] = '{4, 3, 2, 1, 1};
    int acc;
    int acc2;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // volume saturation
        for (int i = 0; i < 3; i++) begin
            vol_up = 1'b1; @(negedge clk); vol_up = 1'b0;
            check("vol_up", int'(vol_num), vup_exp[i]);
        end
        vol_up = 1'b1; vol_dn = 1'b1; @(negedge clk); vol_up = 1'b0; vol_dn = 1'b0;
        check("vol_both", int'(vol_num), 5);
        for (int i = 0; i < 5; i++) begin
            vol_dn = 1'b1; @(negedge clk); vol_dn = 1'b0;
            check("vol_dn", int'(vol_num), vdn_exp[i]);
        end

        // one-shot melody
        loop = 1'b0;
        repeat (2) @(negedge clk);
        pulse_play();
        acc = 0;
        for (int p = 0; p < 18; p++) begin
            acc += int'(done);
            case (p)
                0:  begin check("m1_addr0", int'(mel_addr), 0); check("m1_busy", int'(busy), 1);
                          check("m1_nd0", int'(note_div), 100); end
                4:  begin check("m1_addr1", int'(mel_addr), 1); check("m1_beat", int'(beat), 1); end
                5:  check("m1_beat_low", int'(beat), 0);
                7:  begin check("m1_rest_nd", int'(note_div), 0); check("m1_rest_mute", int'(mute), 1); end
                11: begin check("m1_nd300", int'(note_div), 300); check("m1_unmute", int'(mute), 0); end
                12: check("m1_addr3", int'(mel_addr), 3);
                15: check("m1_nd400", int'(note_div), 400);
                16: begin check("m1_done", int'(done), 1); check("m1_idle", int'(busy), 0);
                          check("m1_addr_end", int'(mel_addr), 0); check("m1_mute_end", int'(mute), 1); end
                default: ;
            endcase
            @(negedge clk);
        end
        check("m1_done_count", acc, 1);

        // looping melody, then stop
        loop = 1'b1;
        repeat (3) @(negedge clk);
        pulse_play();
        acc = 0;
        for (int p = 0; p < 24; p++) begin
            acc += int'(done);
            if (p == 15) check("m2_addr3", int'(mel_addr), 3);
            if (p == 16) begin check("m2_wrap", int'(mel_addr), 0); check("m2_busy", int'(busy), 1); end
            if (p == 20) check("m2_addr1", int'(mel_addr), 1);
            @(negedge clk);
        end
        check("m2_no_done", acc, 0);
        pulse_stop();
        check("m2_stop_busy", int'(busy), 0);
        check("m2_stop_nd", int'(note_div), 0);
        check("m2_stop_mute", int'(mute), 1);
        check("m2_stop_addr", int'(mel_addr), 0);

        // sound effect interrupting note 2
        repeat (3) @(negedge clk);
        pulse_play();
        repeat (9) @(negedge clk);
        pulse_sfx(22'd777, 1'b0);
        acc = 0;
        for (int k = 0; k < 13; k++) begin
            if (k < 12 && note_div == 22'd777) acc++;
            case (k)
                0:  begin check("s1_ack", int'(sfx_ack), 1); check("s1_addr", int'(mel_addr), 2); end
                1:  check("s1_ack_low", int'(sfx_ack), 0);
                8:  begin check("s1_resume_addr", int'(mel_addr), 2); check("s1_resume_nd", int'(note_div), 300);
                          check("s1_resume_busy", int'(busy), 1); end
                11: check("s1_full_beat", int'(mel_addr), 2);
                12: check("s1_next_note", int'(mel_addr), 3);
                default: ;
            endcase
            @(negedge clk);
        end
        check("s1_777_cycles", acc, 8);
        pulse_stop();

        // sfx and play together from idle; repeated sfx_req ignored
        repeat (3) @(negedge clk);
        pulse_sfx(22'd555, 1'b1);
        check("s2_ack", int'(sfx_ack), 1);
        check("s2_nd", int'(note_div), 555);
        @(negedge clk);
        pulse_sfx(22'd999, 1'b0);
        check("s2_no_ack", int'(sfx_ack), 0);
        check("s2_nd_kept", int'(note_div), 555);
        repeat (5) @(negedge clk);
        check("s2_still_sfx", int'(busy), 1);
        @(negedge clk);
        check("s2_back_idle", int'(busy), 0);
        check("s2_addr", int'(mel_addr), 0);
        check("s2_mute", int'(mute), 1);
        @(negedge clk);
        check("s2_stays_idle", int'(busy), 0);

        // reset in the middle of a sound effect
        repeat (2) @(negedge clk);
        pulse_play();
        repeat (6) @(negedge clk);
        pulse_sfx(22'd1234, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_sfx");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc = 0; acc2 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc  += int'(sfx_ack) + int'(done);
            acc2 += int'(busy);
        end
        check("rst_no_pulses", acc, 0);
        check("rst_stays_idle", acc2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
